// File: rtl/ring_sequence_checker.sv
// rtl/ring_sequence_checker.sv - one-hot ring word decoder and rotation sequence monitor
module ring_sequence_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ring_in,
  output logic [IDX_W-1:0] index,
  output logic             index_valid,
  output logic             locked,
  output logic             onehot_error,
  output logic             seq_error,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  // Where a single-sample lock lands after a resync.
  localparam state_t RESYNC_STATE = (LOCK_COUNT == 1) ? S_LOCKED : S_VERIFY;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_expected;
  logic [WIDTH-1:0] w_expected_nxt;
  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] w_match_nxt;
  logic [CNT_W-1:0] w_match_inc;
  logic [IDX_W-1:0] r_index;
  logic             r_index_valid;
  logic             r_locked;
  logic             r_onehot_error;
  logic             r_seq_error;
  logic             r_wrap;
  logic [ERR_W-1:0] r_err_count;

  logic             w_is_onehot;
  logic [WIDTH-1:0] w_rotl;
  logic [IDX_W-1:0] w_pos;
  logic             w_onehot_err;
  logic             w_seq_err;
  logic             w_wrap;
  logic             w_count_err;

  assign w_is_onehot = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
  assign w_rotl      = {ring_in[WIDTH-2:0], ring_in[WIDTH-1]};
  assign w_match_inc = r_match_cnt + CNT_W'(1);

  // Binary position of the set bit; only meaningful when the word is one-hot.
  always_comb begin
    w_pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) begin
        w_pos = IDX_W'(i);
      end
    end
  end

  // State register for the hunt/verify/locked tracker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, expected-word, match counter and event decode for one sample.
  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_match_nxt    = r_match_cnt;
    w_onehot_err   = 1'b0;
    w_seq_err      = 1'b0;
    w_wrap         = 1'b0;
    w_count_err    = 1'b0;
    if (in_valid) begin
      if (!w_is_onehot) begin
        w_onehot_err = 1'b1;
        w_count_err  = (r_state != S_HUNT);
        w_state_nxt  = S_HUNT;
        w_match_nxt  = '0;
      end else begin
        case (r_state)
          S_HUNT: begin
            w_expected_nxt = w_rotl;
            w_match_nxt    = CNT_W'(1);
            w_state_nxt    = RESYNC_STATE;
          end
          S_VERIFY: begin
            w_expected_nxt = w_rotl;
            if (ring_in == r_expected) begin
              w_match_nxt = w_match_inc;
              if (w_match_inc == CNT_W'(LOCK_COUNT)) begin
                w_state_nxt = S_LOCKED;
              end
            end else begin
              w_seq_err   = 1'b1;
              w_count_err = 1'b1;
              w_match_nxt = CNT_W'(1);
              w_state_nxt = RESYNC_STATE;
            end
          end
          S_LOCKED: begin
            w_expected_nxt = w_rotl;
            if (ring_in == r_expected) begin
              w_wrap = ring_in[0];
            end else begin
              w_seq_err   = 1'b1;
              w_count_err = 1'b1;
              w_match_nxt = CNT_W'(1);
              w_state_nxt = RESYNC_STATE;
            end
          end
          default: begin
            w_state_nxt = S_HUNT;
            w_match_nxt = '0;
          end
        endcase
      end
    end
  end

  // Registered tracking data, status outputs and saturating error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_expected     <= '0;
      r_match_cnt    <= '0;
      r_index        <= '0;
      r_index_valid  <= 1'b0;
      r_locked       <= 1'b0;
      r_onehot_error <= 1'b0;
      r_seq_error    <= 1'b0;
      r_wrap         <= 1'b0;
      r_err_count    <= '0;
    end else begin
      r_expected     <= w_expected_nxt;
      r_match_cnt    <= w_match_nxt;
      r_index_valid  <= in_valid && w_is_onehot;
      r_locked       <= (w_state_nxt == S_LOCKED);
      r_onehot_error <= w_onehot_err;
      r_seq_error    <= w_seq_err;
      r_wrap         <= w_wrap;
      if (in_valid && w_is_onehot) begin
        r_index <= w_pos;
      end
      if (w_count_err && (r_err_count != {ERR_W{1'b1}})) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  assign index        = r_index;
  assign index_valid  = r_index_valid;
  assign locked       = r_locked;
  assign onehot_error = r_onehot_error;
  assign seq_error    = r_seq_error;
  assign wrap         = r_wrap;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// tb/tb_ring_sequence_checker.sv - scoreboard bench for ring_sequence_checker
module tb_ring_sequence_checker;

  localparam int W  = 4;
  localparam int LC = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] ring_in = '0;

  logic [1:0] a_index;
  logic       a_iv, a_lk, a_ohe, a_se, a_wr;
  logic [7:0] a_err;
  logic [1:0] b_index;
  logic       b_iv, b_lk, b_ohe, b_se, b_wr;
  logic [1:0] b_err;

  ring_sequence_checker #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ring_in(ring_in),
    .index(a_index), .index_valid(a_iv), .locked(a_lk), .onehot_error(a_ohe),
    .seq_error(a_se), .wrap(a_wr), .err_count(a_err)
  );

  ring_sequence_checker #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ring_in(ring_in),
    .index(b_index), .index_valid(b_iv), .locked(b_lk), .onehot_error(b_ohe),
    .seq_error(b_se), .wrap(b_wr), .err_count(b_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit iv, lk, ohe, se, wr;
    int e8, e2;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: length of the current run of correctly rotating samples.
  int m_run, m_prev, m_idx, m_e8, m_e2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_prev = 0; m_idx = 0; m_e8 = 0; m_e2 = 0;
  endfunction

  function automatic exp_t model_step(input bit v, input logic [W-1:0] w);
    exp_t e;
    bit counted;
    int p;
    bit was_locked;
    e.iv = 0; e.ohe = 0; e.se = 0; e.wr = 0;
    counted = 0;
    if (v) begin
      if ($countones(w) != 1) begin
        e.ohe = 1;
        counted = (m_run > 0);
        m_run = 0;
      end else begin
        p = 0;
        for (int k = 0; k < W; k++) if (w[k]) p = k;
        was_locked = (m_run >= LC);
        if (m_run == 0) begin
          m_run = 1;
        end else if (p == (m_prev + 1) % W) begin
          m_run = (m_run + 1 > LC) ? LC : m_run + 1;
          e.wr = was_locked && (p == 0);
        end else begin
          e.se = 1;
          counted = 1;
          m_run = 1;
        end
        m_prev = p;
        m_idx = p;
        e.iv = 1;
      end
    end
    if (counted) begin
      if (m_e8 < 255) m_e8++;
      if (m_e2 < 3) m_e2++;
    end
    e.idx = m_idx;
    e.lk  = (m_run >= LC);
    e.e8  = m_e8;
    e.e2  = m_e2;
    return e;
  endfunction

  task automatic drive(input bit v, input logic [W-1:0] w);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    ring_in  = w;
    if (reset) e = model_step(v, w);
    else begin
      e = '{idx: 0, iv: 0, lk: 0, ohe: 0, se: 0, wr: 0, e8: 0, e2: 0};
    end
    q.push_back(e);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_locked", a_lk, 0);
    check("async_err", a_err, 0);
    check("async_sat_locked", b_lk, 0);
    check("async_sat_err", b_err, 0);
    drive(0, '0);
    drive(0, '0);
    reset = 1'b1;
  endtask

  // Monitor: every cycle after the edge, compare both instances with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("index", a_index, e.idx);
        check("index_valid", a_iv, e.iv);
        check("locked", a_lk, e.lk);
        check("onehot_error", a_ohe, e.ohe);
        check("seq_error", a_se, e.se);
        check("wrap", a_wr, e.wr);
        check("err_count", a_err, e.e8);
        check("sat_err_count", b_err, e.e2);
        check("sat_locked", b_lk, e.lk);
      end
    end
  end

  initial begin
    int gen_pos;
    int r;
    logic [W-1:0] w;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_index", a_index, 0);
    check("rst_index_valid", a_iv, 0);
    check("rst_locked", a_lk, 0);
    check("rst_pulses", {a_ohe, a_se, a_wr}, 0);
    check("rst_err", a_err, 0);
    reset = 1'b1;

    // Lock-in, wrap and gap
    drive(1, 4'b0001); drive(1, 4'b0010); drive(1, 4'b0100); drive(1, 4'b1000);
    drive(1, 4'b0001);
    drive(0, 4'b0010); drive(0, 4'b1111); drive(0, 4'b0000);
    drive(1, 4'b0010);
    // Sequence skip then relock
    drive(1, 4'b1000);
    drive(1, 4'b0001); drive(1, 4'b0010); drive(1, 4'b0100);
    // One-hot violations: counted while locked, not counted in hunt
    drive(1, 4'b0110);
    drive(1, 4'b0000);
    // Five counted sequence errors saturate the narrow counter
    drive(1, 4'b0001);
    repeat (5) drive(1, 4'b0001);
    drive(1, 4'b0010); drive(1, 4'b0100); drive(1, 4'b1000);

    // Build locked with two errors, then reset asynchronously
    async_reset();
    drive(1, 4'b0001); drive(1, 4'b0010); drive(1, 4'b0100); drive(1, 4'b1000);
    drive(1, 4'b0100);
    drive(1, 4'b1000); drive(1, 4'b0001); drive(1, 4'b0010);
    drive(1, 4'b0001);
    drive(1, 4'b0010); drive(1, 4'b0100); drive(1, 4'b1000);
    @(negedge clk);
    check("prelock_locked", a_lk, 1);
    check("prelock_err", a_err, 2);
    async_reset();
    drive(1, 4'b0100);
    drive(0, 4'b0000);

    // Randomized traffic with occasional asynchronous resets
    gen_pos = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      r = $urandom_range(0, 99);
      if (r < 80) begin
        gen_pos = (gen_pos + 1) % W;
        w = W'(1) << gen_pos;
      end else if (r < 90) begin
        gen_pos = $urandom_range(0, W - 1);
        w = W'(1) << gen_pos;
      end else begin
        w = W'($urandom_range(0, 15));
      end
      drive($urandom_range(0, 3) != 0, w);
    end
    drive(0, '0);
    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
